// File: rtl/button_event_pkg.sv
// Shared constants and types for the button event generator: button indices,
// event encoding and the auto-repeat state enum.
package button_event_pkg;

  localparam int NUM_BUTTONS = 12;
  localparam int CODE_W      = 4;
  localparam int EVENT_W     = CODE_W + 1;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_X      = 8;
  localparam int BTN_Y      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam logic [NUM_BUTTONS-1:0] DPAD_MASK = 12'h0F0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_BUTTONS-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small valid/ready FIFO with a combinational head; a push and a pop may share
// a cycle at any occupancy, including full.
module event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == (AW + 1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  // A full queue can still take a new entry while its head leaves.
  assign in_ready  = !full || out_ready;
  assign do_push   = in_valid && in_ready;
  assign do_pop    = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Synchronizes controller buttons, emits press/release pulses and queues press
// events. Define BUTTON_AUTOREPEAT_EN to compile in D-pad auto-repeat.
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   system_clk_50MHz,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic                   controller_status,
  input  logic                   frame_tick,
  output logic [NUM_BUTTONS-1:0] held,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [CODE_W-1:0]      event_code,
  output logic                   event_repeat,
  output logic                   overflow
);
  localparam int SW = NUM_BUTTONS + 1;

  logic [SYNC_STAGES*SW-1:0] sync_reg;
  logic [SW-1:0]             sync_out;
  logic                      sync_status;
  logic [NUM_BUTTONS-1:0]    held_prev_reg;

  logic [NUM_BUTTONS-1:0]    pending_reg, pending_next;
  logic [NUM_BUTTONS-1:0]    pending_rep_reg, pending_rep_next;
  logic                      overflow_reg, overflow_next;
  logic [NUM_BUTTONS-1:0]    rep_set;
  logic [NUM_BUTTONS-1:0]    clear_vec;
  logic [NUM_BUTTONS-1:0]    keep_vec;

  logic                      push_valid;
  logic                      push_ready;
  logic [CODE_W-1:0]         push_sel;
  logic [EVENT_W-1:0]        push_data;
  logic [EVENT_W-1:0]        head_data;

  assign sync_out    = sync_reg[SYNC_STAGES*SW-1 -: SW];
  assign sync_status = sync_out[NUM_BUTTONS];
  assign held        = sync_out[NUM_BUTTONS-1:0] & {NUM_BUTTONS{sync_status}};

  // Loss of the controller drops held silently: releases only count while present.
  assign press_pulse   = held & ~held_prev_reg;
  assign release_pulse = held_prev_reg & ~held & {NUM_BUTTONS{sync_status}};

  always_ff @(posedge system_clk_50MHz or posedge reset) begin
    if (reset) begin
      sync_reg        <= '0;
      held_prev_reg   <= '0;
      pending_reg     <= '0;
      pending_rep_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      sync_reg        <= {sync_reg[(SYNC_STAGES-1)*SW-1:0], controller_status, buttons_in};
      held_prev_reg   <= held;
      pending_reg     <= pending_next;
      pending_rep_reg <= pending_rep_next;
      overflow_reg    <= overflow_next;
    end
  end

  always_comb begin
    push_valid       = (pending_reg != '0);
    push_sel         = lowest_set(pending_reg);
    push_data        = {push_sel, pending_rep_reg[push_sel]};
    clear_vec        = (push_valid && push_ready) ? (NUM_BUTTONS'(1) << push_sel) : '0;
    keep_vec         = pending_reg & ~clear_vec;
    pending_next     = keep_vec;
    pending_rep_next = pending_rep_reg;
    overflow_next    = overflow_reg;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (press_pulse[i]) begin
        pending_next[i]     = 1'b1;
        pending_rep_next[i] = 1'b0;
        if (keep_vec[i]) overflow_next = 1'b1;
      end else if (rep_set[i]) begin
        // A repeat landing on a still-queued fresh press keeps the fresh tag.
        pending_next[i] = 1'b1;
        if (!keep_vec[i]) pending_rep_next[i] = 1'b1;
      end
    end
  end

  event_fifo #(
    .WIDTH(EVENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (system_clk_50MHz),
    .rst      (reset),
    .in_valid (push_valid),
    .in_ready (push_ready),
    .in_data  (push_data),
    .out_valid(event_valid),
    .out_ready(event_ready),
    .out_data (head_data)
  );

  assign event_code = head_data[EVENT_W-1:1];
  assign overflow   = overflow_reg;

`ifdef BUTTON_AUTOREPEAT_EN
  rep_state_t             state_reg, state_next;
  logic [CODE_W-1:0]      rep_btn_reg, rep_btn_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic                   rep_fire;
  logic [NUM_BUTTONS-1:0] dpad_press;

  assign dpad_press = press_pulse & DPAD_MASK;

  always_ff @(posedge system_clk_50MHz or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rep_btn_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      rep_btn_reg <= rep_btn_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rep_btn_next = rep_btn_reg;
    cnt_next     = cnt_reg;
    rep_fire     = 1'b0;
    if (dpad_press != '0) begin
      state_next   = ST_DELAY;
      rep_btn_next = lowest_set(dpad_press);
      cnt_next     = '0;
    end else if (state_reg != ST_IDLE) begin
      // held is already cleared on controller loss, so this covers both exits.
      if (!held[rep_btn_reg]) begin
        state_next = ST_IDLE;
      end else if (frame_tick) begin
        if (cnt_reg == ((state_reg == ST_DELAY) ? 8'(REPEAT_DELAY - 1) : 8'(REPEAT_RATE - 1))) begin
          rep_fire   = 1'b1;
          cnt_next   = '0;
          state_next = ST_REPEAT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rep_set      = rep_fire ? (NUM_BUTTONS'(1) << rep_btn_reg) : '0;
  assign event_repeat = head_data[0];
`else
  logic [16:0] unused_cfg;
  logic        unused_rep;

  assign rep_set      = '0;
  assign event_repeat = 1'b0;
  assign unused_cfg   = {frame_tick, 8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
  assign unused_rep   = head_data[0];
`endif

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on button/status inputs (legal 2..3).
REQ-002 Parameter REPEAT_DELAY, default 20: frame_tick count before first auto-repeat (legal 1..255).
REQ-003 Parameter REPEAT_RATE, default 6: frame_tick count between subsequent repeats (legal 1..255).
REQ-004 Parameter FIFO_DEPTH, default 4: event FIFO entries (power of 2, 2..16).
REQ-005 system_clk_50MHz  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 buttons_in  input  12  decoded button levels, 1=pressed; bit 0..11 = A,B,select,start,up,down,left,right,X,Y,L,R.
REQ-008 controller_status  input  1  1 = controller present/valid.
REQ-009 frame_tick  input  1  single-cycle frame strobe.
REQ-010 held  output  12  debounced-synchronized pressed state.
REQ-011 press_pulse  output  12  one-cycle pulse per newly pressed button.
REQ-012 release_pulse  output  12  one-cycle pulse per newly released button.
REQ-013 event_valid  output  1  FIFO head valid.
REQ-014 event_ready  input  1  consumer accepts head when valid&ready.
REQ-015 event_code  output  4  button index of head event.
REQ-016 event_repeat  output  1  head event is auto-repeat, not fresh press.
REQ-017 overflow  output  1  sticky: a press was coalesced into an already-pending one.

Function
REQ-018 buttons_in and controller_status SHALL pass through SYNC_STAGES flops; held = synced buttons AND synced status.
REQ-019 held SHALL update SYNC_STAGES cycles after an input change; press_pulse/release_pulse SHALL assert in the same cycle held changes, for exactly one cycle.
REQ-020 Synced status falling SHALL force held to 0 with no release pulses, and SHALL clear repeat state; pending and FIFO contents retained.
REQ-021 Each press SHALL set pending[i] (pending_rep[i]=0); a press on an already-pending bit SHALL set overflow.
REQ-022 Each cycle the FIFO is not full, the lowest-index pending bit SHALL be pushed {index, pending_rep} and cleared; at most one push per cycle.
REQ-023 Push and pop in the same cycle SHALL be allowed at any occupancy, including full; count unchanged.
REQ-024 When the FIFO is full, pending bits SHALL hold, never drop.
REQ-025 event_code/event_repeat SHALL be stable while event_valid&!event_ready; minimum push-to-valid latency 1 cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; pop on empty and push on full SHALL be ignored.

Reset
REQ-027 Reset SHALL clear synchronizers, held, pulses, pending, FIFO, overflow, repeat FSM to IDLE; all outputs 0.
REQ-028 Buttons held when reset deasserts SHALL produce press events after SYNC_STAGES cycles.
REQ-029 Reset mid-operation SHALL discard queued events immediately.

Configuration
REQ-030 Macro BUTTON_AUTOREPEAT_EN defined: D-pad (bits 4..7) auto-repeat FSM compiled in.
REQ-031 FSM states IDLE, DELAY, REPEAT; D-pad press (any state) -> DELAY, rep_btn=i, cnt=0.
REQ-032 In DELAY/REPEAT cnt increments on frame_tick; at tick with cnt = REPEAT_DELAY-1 (DELAY) or REPEAT_RATE-1 (REPEAT) set pending[rep_btn] with pending_rep=1, cnt=0, go REPEAT.
REQ-033 held[rep_btn] falling or status loss SHALL return FSM to IDLE same cycle.
REQ-034 Macro undefined: no FSM/counter logic; event_repeat tied 0.

Structure
REQ-035 Package button_event_pkg SHALL hold NUM_BUTTONS=12, button index constants, event width, FSM state enum.
REQ-036 Sub-module event_fifo (parameterized width/depth, valid/ready) SHALL implement the queue.

Verification
REQ-037 Press A (bit 0) after reset -> held[0] and press_pulse[0] 2 cycles later; event_code=0, event_repeat=0.
REQ-038 Press A, start, R same cycle, ready=1 -> events 0,3,11 on consecutive cycles.
REQ-039 ready=0, 6 distinct presses, FIFO_DEPTH=4 -> 4 queued, 2 pending; release ready -> all 6 delivered in index order, overflow=0.
REQ-040 Press A twice while FIFO full and pending[0] set -> overflow=1, one A event delivered for second press.
REQ-041 With BUTTON_AUTOREPEAT_EN, hold up for 40 ticks -> fresh event at press, repeats (code 4, repeat=1) at ticks 20, 26, 32, 38.
REQ-042 Drop controller_status while up held -> held=0, no release_pulse, no further repeats.
